// File: rtl/soc_req_arbiter.sv
// Round-robin arbiter merging NumReq request channels onto one SoC port, with an
// in-order ID FIFO that routes each SoC response back to the requester that issued it.
module soc_req_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned IdxW          = $clog2(NumReq),
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_qaddr_i,
    input  logic [NumReq-1:0]                   req_qwrite_i,
    input  logic [NumReq-1:0][3:0]              req_qamo_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_qdata_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]    req_qstrb_i,
    input  logic [NumReq-1:0]                   req_qvalid_i,
    output logic [NumReq-1:0]                   req_qready_o,
    output logic [NumReq-1:0][DataWidth-1:0]    req_pdata_o,
    output logic [NumReq-1:0]                   req_pwrite_o,
    output logic [NumReq-1:0]                   req_perror_o,
    output logic [NumReq-1:0]                   req_pvalid_o,
    input  logic [NumReq-1:0]                   req_pready_i,
    output logic [AddrWidth-1:0]                soc_qaddr_o,
    output logic                                soc_qwrite_o,
    output logic [3:0]                          soc_qamo_o,
    output logic [DataWidth-1:0]                soc_qdata_o,
    output logic [StrbWidth-1:0]                soc_qstrb_o,
    output logic                                soc_qvalid_o,
    input  logic                                soc_qready_i,
    input  logic [DataWidth-1:0]                soc_pdata_i,
    input  logic                                soc_pwrite_i,
    input  logic                                soc_perror_i,
    input  logic                                soc_pvalid_i,
    output logic                                soc_pready_o,
    output logic [CntW-1:0]                     outstanding_o,
    output logic                                unexpected_rsp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    if (NumReq < 2) begin : g_chk_numreq
        $error("soc_req_arbiter: NumReq must be >= 2");
    end
    if (MaxOutstanding < 1) begin : g_chk_maxout
        $error("soc_req_arbiter: MaxOutstanding must be >= 1");
    end
    if ((DataWidth % 8) != 0) begin : g_chk_dw
        $error("soc_req_arbiter: DataWidth must be a multiple of 8");
    end

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [IdxW-1:0] fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            unexpected_q, unexpected_d;

    logic            full;
    logic            empty;
    logic            found;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] head;
    logic [IdxW-1:0] cand_idx;
    logic            push;
    logic            pop;
    int              cand;

    // Full is taken from registered occupancy only, so a pop never frees a slot in its own cycle.
    always_comb begin
        full     = (cnt_q == CntW'(MaxOutstanding));
        empty    = (cnt_q == '0);
        found    = 1'b0;
        grant    = rr_q;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cand = int'(rr_q) + i;
            if (cand >= int'(NumReq)) begin
                cand = cand - int'(NumReq);
            end
            cand_idx = IdxW'(cand);
            if (!found && req_qvalid_i[cand_idx]) begin
                found = 1'b1;
                grant = cand_idx;
            end
        end
        if (lock_q) begin
            grant = lock_idx_q;
        end

        soc_qvalid_o = !full && ((|req_qvalid_i) || lock_q);
        soc_qaddr_o  = req_qaddr_i[grant];
        soc_qwrite_o = req_qwrite_i[grant];
        soc_qamo_o   = req_qamo_i[grant];
        soc_qdata_o  = req_qdata_i[grant];
        soc_qstrb_o  = req_qstrb_i[grant];

        push         = soc_qvalid_o && soc_qready_i;
        req_qready_o = '0;
        if (push) begin
            req_qready_o[grant] = 1'b1;
        end

        head         = fifo_q[rd_ptr_q];
        req_pvalid_o = '0;
        soc_pready_o = 1'b0;
        if (empty) begin
            soc_pready_o = soc_pvalid_i;
        end else begin
            req_pvalid_o[head] = soc_pvalid_i;
            soc_pready_o       = req_pready_i[head];
        end
        pop = !empty && soc_pvalid_i && soc_pready_o;

        for (int i = 0; i < int'(NumReq); i++) begin
            req_pdata_o[i]  = soc_pdata_i;
            req_pwrite_o[i] = soc_pwrite_i;
            req_perror_o[i] = soc_perror_i;
        end
    end

    // An unacknowledged grant locks onto its requester so the SoC payload stays stable.
    always_comb begin
        rr_d         = rr_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q + CntW'(push) - CntW'(pop);
        unexpected_d = unexpected_q || (empty && soc_pvalid_i);

        if (push) begin
            lock_d           = 1'b0;
            rr_d             = (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        end else if (soc_qvalid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            fifo_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            unexpected_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            unexpected_q <= unexpected_d;
        end
    end

    assign outstanding_o    = cnt_q;
    assign unexpected_rsp_o = unexpected_q;

endmodule

// File: tb/tb_soc_req_arbiter.sv
// Bench for soc_req_arbiter: table-driven request vectors with a scoreboard of
// expected response routes; MaxOutstanding is set to 2 so the full case is reachable.
module tb_soc_req_arbiter;

    typedef struct {
        logic [3:0] qvalid;
        logic       soc_qready;
        logic       soc_pvalid;
        logic [3:0] pready;
        logic       exp_qvalid;
        logic [3:0] exp_qready;
        logic [1:0] exp_grant;
        logic [1:0] exp_out;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0][31:0]  req_qaddr_i;
    logic [3:0]        req_qwrite_i;
    logic [3:0][3:0]   req_qamo_i;
    logic [3:0][31:0]  req_qdata_i;
    logic [3:0][3:0]   req_qstrb_i;
    logic [3:0]        req_qvalid_i;
    logic [3:0]        req_qready_o;
    logic [3:0][31:0]  req_pdata_o;
    logic [3:0]        req_pwrite_o;
    logic [3:0]        req_perror_o;
    logic [3:0]        req_pvalid_o;
    logic [3:0]        req_pready_i;
    logic [31:0]       soc_qaddr_o;
    logic              soc_qwrite_o;
    logic [3:0]        soc_qamo_o;
    logic [31:0]       soc_qdata_o;
    logic [3:0]        soc_qstrb_o;
    logic              soc_qvalid_o;
    logic              soc_qready_i;
    logic [31:0]       soc_pdata_i;
    logic              soc_pwrite_i;
    logic              soc_perror_i;
    logic              soc_pvalid_i;
    logic              soc_pready_o;
    logic [1:0]        outstanding_o;
    logic              unexpected_rsp_o;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb [$];
    vec_t fair_tbl [7];

    soc_req_arbiter #(
        .NumReq(4), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_qaddr_i(req_qaddr_i), .req_qwrite_i(req_qwrite_i), .req_qamo_i(req_qamo_i),
        .req_qdata_i(req_qdata_i), .req_qstrb_i(req_qstrb_i), .req_qvalid_i(req_qvalid_i),
        .req_qready_o(req_qready_o), .req_pdata_o(req_pdata_o), .req_pwrite_o(req_pwrite_o),
        .req_perror_o(req_perror_o), .req_pvalid_o(req_pvalid_o), .req_pready_i(req_pready_i),
        .soc_qaddr_o(soc_qaddr_o), .soc_qwrite_o(soc_qwrite_o), .soc_qamo_o(soc_qamo_o),
        .soc_qdata_o(soc_qdata_o), .soc_qstrb_o(soc_qstrb_o), .soc_qvalid_o(soc_qvalid_o),
        .soc_qready_i(soc_qready_i), .soc_pdata_i(soc_pdata_i), .soc_pwrite_i(soc_pwrite_i),
        .soc_perror_i(soc_perror_i), .soc_pvalid_i(soc_pvalid_i), .soc_pready_o(soc_pready_o),
        .outstanding_o(outstanding_o), .unexpected_rsp_o(unexpected_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] addrOf(input logic [1:0] idx);
        return 32'h1000_0000 + {26'd0, idx, 4'd0};
    endfunction

    function automatic logic [31:0] dataOf(input logic [1:0] idx);
        return 32'hCAFE_0000 + {30'd0, idx};
    endfunction

    function automatic vec_t mkVec(input logic [3:0] qv, input logic qr, input logic pv,
                                   input logic [3:0] pr, input logic eqv, input logic [3:0] eqr,
                                   input logic [1:0] eg, input logic [1:0] eo);
        vec_t v;
        v.qvalid = qv; v.soc_qready = qr; v.soc_pvalid = pv; v.pready = pr;
        v.exp_qvalid = eqv; v.exp_qready = eqr; v.exp_grant = eg; v.exp_out = eo;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drives one cycle, checks the combinational outputs mid-cycle, then steps past the edge.
    task automatic applyStimulus(input vec_t v, input string nm);
        logic [3:0] exp_pv;
        logic       exp_pr;
        logic [1:0] front;
        req_qvalid_i = v.qvalid;
        soc_qready_i = v.soc_qready;
        soc_pvalid_i = v.soc_pvalid;
        req_pready_i = v.pready;
        soc_pdata_i  = $urandom;
        soc_pwrite_i = 1'($urandom_range(0, 1));
        soc_perror_i = 1'($urandom_range(0, 1));
        #3;
        checkOutput({nm, ".soc_qvalid"}, {31'd0, soc_qvalid_o}, {31'd0, v.exp_qvalid});
        checkOutput({nm, ".req_qready"}, {28'd0, req_qready_o}, {28'd0, v.exp_qready});
        checkOutput({nm, ".outstanding"}, {30'd0, outstanding_o}, {30'd0, v.exp_out});
        if (v.exp_qvalid) begin
            checkOutput({nm, ".soc_qaddr"}, soc_qaddr_o, addrOf(v.exp_grant));
            checkOutput({nm, ".soc_qdata"}, soc_qdata_o, dataOf(v.exp_grant));
        end
        exp_pv = 4'b0000;
        exp_pr = 1'b0;
        front  = 2'd0;
        if (v.soc_pvalid) begin
            if (sb.size() == 0) begin
                exp_pr = 1'b1;
            end else begin
                front         = sb[0];
                exp_pv[front] = 1'b1;
                exp_pr        = v.pready[front];
            end
        end
        checkOutput({nm, ".req_pvalid"}, {28'd0, req_pvalid_o}, {28'd0, exp_pv});
        checkOutput({nm, ".soc_pready"}, {31'd0, soc_pready_o}, {31'd0, exp_pr});
        if (exp_pv != 4'b0000) begin
            checkOutput({nm, ".req_pdata"}, req_pdata_o[front], soc_pdata_i);
            checkOutput({nm, ".req_perror"}, {31'd0, req_perror_o[front]}, {31'd0, soc_perror_i});
            if (exp_pr) begin
                void'(sb.pop_front());
            end
        end
        if (v.exp_qvalid && v.soc_qready) begin
            sb.push_back(v.exp_grant);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_qaddr_i[i]  = addrOf(2'(i));
            req_qdata_i[i]  = dataOf(2'(i));
            req_qamo_i[i]   = 4'(i);
            req_qstrb_i[i]  = 4'hF ^ 4'(i);
            req_qwrite_i[i] = 1'(i);
        end
        rst_i = 1'b1;
        req_qvalid_i = '0; soc_qready_i = 1'b0; soc_pvalid_i = 1'b0; req_pready_i = '0;
        soc_pdata_i = '0; soc_pwrite_i = 1'b0; soc_perror_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;

        checkOutput("rst.soc_qvalid", {31'd0, soc_qvalid_o}, 32'd0);
        checkOutput("rst.req_pvalid", {28'd0, req_pvalid_o}, 32'd0);
        checkOutput("rst.soc_pready", {31'd0, soc_pready_o}, 32'd0);
        checkOutput("rst.outstanding", {30'd0, outstanding_o}, 32'd0);
        checkOutput("rst.unexpected", {31'd0, unexpected_rsp_o}, 32'd0);
        rst_i = 1'b0;

        // Fairness: all valid, ready always, responses one cycle later.
        fair_tbl[0] = mkVec(4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 2'd0);
        fair_tbl[1] = mkVec(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 2'd1);
        fair_tbl[2] = mkVec(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 2'd1);
        fair_tbl[3] = mkVec(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 2'd1);
        fair_tbl[4] = mkVec(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 2'd1);
        fair_tbl[5] = mkVec(4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1);
        fair_tbl[6] = mkVec(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(fair_tbl[i], $sformatf("fair%0d", i));
        end

        // Lock: rr points at 1, req1 held for three stalled cycles before req2 goes.
        applyStimulus(mkVec(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 2'd0), "lock0");
        applyStimulus(mkVec(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 2'd0), "lock1");
        applyStimulus(mkVec(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 2'd0), "lock2");
        applyStimulus(mkVec(4'b0110, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1, 2'd0), "lock3");
        applyStimulus(mkVec(4'b0100, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 2'd1), "lock4");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1), "lock5");
        // Lock on req0 must override rr=3 when req3 raises valid mid-stall.
        applyStimulus(mkVec(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0), "lock6");
        applyStimulus(mkVec(4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0), "lock7");
        applyStimulus(mkVec(4'b1001, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd0), "lock8");
        applyStimulus(mkVec(4'b1000, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 2'd1), "lock9");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1), "lock10");

        // Full: two accepted, then blocked even in the pop cycle.
        applyStimulus(mkVec(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd0), "full0");
        applyStimulus(mkVec(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1, 2'd1), "full1");
        applyStimulus(mkVec(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd2), "full2");
        applyStimulus(mkVec(4'b1111, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd2), "full3");
        applyStimulus(mkVec(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2, 2'd1), "full4");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd2), "full5");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1), "full6");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0), "full7");

        // Routing with backpressure: req3 then req0, first response stalled two cycles.
        applyStimulus(mkVec(4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b1000, 2'd3, 2'd0), "route0");
        applyStimulus(mkVec(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd1), "route1");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b0111, 1'b0, 4'b0000, 2'd0, 2'd2), "route2");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b0111, 1'b0, 4'b0000, 2'd0, 2'd2), "route3");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd2), "route4");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1), "route5");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0), "route6");

        // Concurrent push and pop with one entry outstanding.
        applyStimulus(mkVec(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2, 2'd0), "conc0");
        applyStimulus(mkVec(4'b0010, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 2'd1), "conc1");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1), "conc2");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0), "conc3");

        // Unexpected response with empty FIFO, sticky until reset.
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0), "unexp0");
        checkOutput("unexp0.flag", {31'd0, unexpected_rsp_o}, 32'd1);
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0), "unexp1");
        checkOutput("unexp1.flag", {31'd0, unexpected_rsp_o}, 32'd1);
        applyStimulus(mkVec(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd0), "unexp2");
        checkOutput("unexp2.flag", {31'd0, unexpected_rsp_o}, 32'd1);
        checkOutput("unexp2.outstanding", {30'd0, outstanding_o}, 32'd1);

        rst_i = 1'b1;
        req_qvalid_i = '0; soc_qready_i = 1'b0; soc_pvalid_i = 1'b0; req_pready_i = '0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb.delete();
        checkOutput("rst2.unexpected", {31'd0, unexpected_rsp_o}, 32'd0);
        checkOutput("rst2.outstanding", {30'd0, outstanding_o}, 32'd0);
        // rr was 1 before reset; a fresh grant to req0 shows it returned to 0.
        applyStimulus(mkVec(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0), "rst2a");
        applyStimulus(mkVec(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 2'd0), "rst2b");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 2'd1), "rst2c");
        applyStimulus(mkVec(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0), "rst2d");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_req_arbiter.md
# soc_req_arbiter

Arbitrates the SoC request channels of `NumReq` core-side TCDM shims onto one shared SoC port, using round-robin arbitration. It tracks the requester of every outstanding transaction in an in-order ID FIFO and routes each SoC response back to the requester that issued it. It sits between the per-core shims' SoC channels and the group-level SoC/AXI bridge. The SoC side returns responses in request order.

## Interface
- `NumReq`, 4: number of requesters; must be ≥ 2.
- `AddrWidth`, 32: address width.
- `DataWidth`, 32: data width; `StrbWidth = DataWidth/8`.
- `MaxOutstanding`, 8: maximum accepted-but-unanswered transactions; must be ≥ 1.
- Derived widths: `IdxW = $clog2(NumReq)` and `CntW = $clog2(MaxOutstanding+1)`.

Ports (clock and reset first):
- `clk_i` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst_i` in 1: reset. **Synchronous, active-high.**
- `req_qaddr_i` in [NumReq][AddrWidth]: request address.
- `req_qwrite_i` in [NumReq]: write flag.
- `req_qamo_i` in [NumReq][4]: AMO opcode.
- `req_qdata_i` in [NumReq][DataWidth]: write data.
- `req_qstrb_i` in [NumReq][StrbWidth]: byte strobes.
- `req_qvalid_i` in [NumReq]: request valid.
- `req_qready_o` out [NumReq]: request accepted.
- `req_pdata_o` out [NumReq][DataWidth]: response data; broadcast to all requesters.
- `req_pwrite_o` out [NumReq]: response write flag; broadcast.
- `req_perror_o` out [NumReq]: response error flag; broadcast.
- `req_pvalid_o` out [NumReq]: response valid, one-hot or zero.
- `req_pready_i` in [NumReq]: response ready.
- `soc_qaddr_o`, `soc_qwrite_o`, `soc_qamo_o`, `soc_qdata_o`, `soc_qstrb_o` out: payload of the granted request.
- `soc_qvalid_o` out 1, `soc_qready_i` in 1: SoC request handshake.
- `soc_pdata_i`, `soc_pwrite_i`, `soc_perror_i` in: SoC response payload.
- `soc_pvalid_i` in 1, `soc_pready_o` out 1: SoC response handshake.
- `outstanding_o` out CntW: current FIFO occupancy.
- `unexpected_rsp_o` out 1: sticky flag; a response arrived with no transaction outstanding.

## Operation
Request arbitration:
- State: round-robin pointer `rr_q` (IdxW), lock flag `lock_q`, locked index `lock_idx_q`, ID FIFO (depth MaxOutstanding, width IdxW) and occupancy count `cnt_q`.
- `full = (cnt_q == MaxOutstanding)`, evaluated on registered state only. There is no pop-bypass: if full, no grant is made, even when a pop happens in the same cycle.
- Grant selection when not full and not locked: the first index with `req_qvalid_i` set, searching `rr_q, rr_q+1, …` modulo NumReq.
- When locked: the grant is `lock_idx_q`, irrespective of `rr_q`.
- `soc_qvalid_o = !full & (any valid | lock_q)`. The SoC payload is muxed from the granted index.
- `req_qready_o[g] = soc_qready_i & soc_qvalid_o`; every other bit is 0.
- Grant made and `soc_qready_i` low: set `lock_q` and capture `lock_idx_q = g`. The grant then holds until the handshake, which keeps the SoC payload stable. A requester must not drop valid once asserted.
- On a request handshake with grant g:
  - clear `lock_q`;
  - set `rr_q = (g+1) mod NumReq`;
  - push g into the FIFO.

Response routing:
- The FIFO head `h` is valid when `cnt_q != 0`.
- `req_pvalid_o[h] = soc_pvalid_i`; all other bits are 0. `soc_pready_o = req_pready_i[h]`.
- A response handshake pops the FIFO.
- Simultaneous push and pop: `cnt_q` is unchanged and the FIFO pointers advance correctly.
- `cnt_q == 0` and `soc_pvalid_i`: assert `soc_pready_o = 1` (the response is dropped), all `req_pvalid_o` stay 0, and `unexpected_rsp_o` is set until reset.
- A response cannot belong to a request accepted in the same cycle. The downstream latency is ≥ 1 cycle by contract.

Reset values:
- Registers: `rr_q = 0`, `lock_q = 0`, FIFO empty, `cnt_q = 0`, `unexpected_rsp_o = 0`.
- Outputs therefore come out of reset as: `soc_qvalid_o = 0` unless a requester is valid, all `req_pvalid_o = 0`, `soc_pready_o = 0`, `outstanding_o = 0`.
- Reset in the middle of a transaction discards all outstanding IDs. The SoC side must be reset together with this block.

## Timing
- Request path is combinational, zero cycles: `req_qvalid_i` to `soc_qvalid_o`/payload, and `soc_qready_i` to `req_qready_o`.
- Response path is combinational, zero cycles: `soc_pvalid_i` to `req_pvalid_o`, and `req_pready_i` to `soc_pready_o`.
- Throughput: one request and one response per cycle.
- Arbitration state (`rr_q`, lock) updates on the edge after a handshake. The next grant uses the new pointer in the following cycle.
- `outstanding_o` reflects `cnt_q`, i.e. the value registered one edge after a push or pop.
- Elaboration checks: `NumReq ≥ 2`, `MaxOutstanding ≥ 1`, `DataWidth % 8 == 0`.

## Test plan
- **Fairness:** NumReq=4, all four valid, `soc_qready_i = 1` continuously, immediate responses. Grant order must be 0,1,2,3,0 and each requester receives its own response in order.
- **Lock/stability:** req1 and req2 valid, `rr_q = 1`, `soc_qready_i` low for 3 cycles. `soc_qaddr_o` stays at req1's address for all 3 cycles. req2 is granted only after req1's handshake.
- **Full:** MaxOutstanding=2 and no responses. Exactly 2 requests are accepted and `outstanding_o = 2`. In the 3rd cycle `soc_qvalid_o = 0` and all `req_qready_o = 0`. After one response pops, a 3rd request is accepted on the following cycle, not in the pop cycle.
- **Response routing with backpressure:** requests accepted from req3 then req0. Response 1 with `req_pready_i[3] = 0` for 2 cycles: `soc_pready_o = 0` and `req_pvalid_o = 4'b1000` are held. Response 2 then routes with `req_pvalid_o = 4'b0001`.
- **Concurrent push/pop:** `cnt = 1`, with a request handshake and a response handshake in the same cycle. `outstanding_o` stays 1 and the next response routes to the newly pushed index.
- **Unexpected response and reset:** `soc_pvalid_i` pulsed with an empty FIFO. `soc_pready_o = 1`, no `req_pvalid_o`, and `unexpected_rsp_o` stays 1 until `rst_i`. After `rst_i` is high for 1 cycle, the flag, `outstanding_o` and `rr_q` are all 0.
